// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register "none" and run-state.
// Also holds the pipeline control vector type used by the hazard controller.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE    = 4'hF;

   localparam logic [2:0] S_AOK    = 3'd1;
   localparam logic [2:0] S_HLT    = 3'd2;
   localparam logic [2:0] S_ADR    = 3'd3;
   localparam logic [2:0] S_INS    = 3'd4;

   typedef enum logic [1:0] {
      RS_INIT = 2'd0,
      RS_RUN  = 2'd1,
      RS_HALT = 2'd2
   } run_state_t;

   typedef struct packed {
      logic f_stall;
      logic d_stall;
      logic d_bubble;
      logic e_bubble;
      logic m_bubble;
      logic w_stall;
      logic set_cc;
   } ctrl_t;

   function automatic logic is_exc(input logic [2:0] stat);
      return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-status inputs and pipeline-register controls exchanged between the
// Y86-64 datapath (master) and the hazard/run-state controller (slave).
interface pipe_ctrl_if;

   logic [3:0] D_icode;
   logic [3:0] d_srcA;
   logic [3:0] d_srcB;
   logic [3:0] E_icode;
   logic [3:0] E_dstM;
   logic       e_Cnd;
   logic [3:0] M_icode;
   logic [2:0] m_stat;
   logic [3:0] W_icode;
   logic [2:0] W_stat;

   logic F_stall;
   logic D_stall;
   logic D_bubble;
   logic E_bubble;
   logic M_bubble;
   logic W_stall;
   logic set_cc;

   modport master (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
   );

   modport slave (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load/use, pending ret, branch mispredict and
// exceptions, folded into the pipeline control vector used while running.
module hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_dstM,
   input  logic       e_Cnd,
   input  logic [3:0] M_icode,
   input  logic [2:0] m_stat,
   input  logic [2:0] W_stat,
   output ctrl_t      run_ctrl
);

   logic load_use;
   logic ret_pend;
   logic mispred;
   logic exc_m;
   logic exc_w;

   always_comb begin
      load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      mispred  = (E_icode == I_JXX) && !e_Cnd;
      exc_m    = is_exc(m_stat);
      exc_w    = is_exc(W_stat);

      // A load/use stall holds the ret in D, so it must not also be bubbled.
      run_ctrl.f_stall  = load_use || ret_pend;
      run_ctrl.d_stall  = load_use;
      run_ctrl.d_bubble = mispred || (!load_use && ret_pend);
      run_ctrl.e_bubble = mispred || load_use;
      run_ctrl.m_bubble = exc_m || exc_w;
      run_ctrl.w_stall  = exc_w;
      run_ctrl.set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline controller: INIT/RUN/HALT run-state, control overrides per
// state, sticky program status and free-running performance counters.
module pipe_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_ctrl_if.slave       pipe,
   output logic [1:0]       run_state,
   output logic [2:0]       prog_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   run_state_t state;
   ctrl_t      run_ctrl;
   ctrl_t      ctrl;

   hazard_detect u_hazard (
      .D_icode  (pipe.D_icode),
      .d_srcA   (pipe.d_srcA),
      .d_srcB   (pipe.d_srcB),
      .E_icode  (pipe.E_icode),
      .E_dstM   (pipe.E_dstM),
      .e_Cnd    (pipe.e_Cnd),
      .M_icode  (pipe.M_icode),
      .m_stat   (pipe.m_stat),
      .W_stat   (pipe.W_stat),
      .run_ctrl (run_ctrl)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      ctrl = '0;
      unique case (state)
         RS_RUN:  ctrl = run_ctrl;
         RS_HALT: begin
            ctrl.f_stall = 1'b1;
            ctrl.d_stall = 1'b1;
            ctrl.w_stall = 1'b1;
         end
         default: begin
            ctrl.d_bubble = 1'b1;
            ctrl.e_bubble = 1'b1;
            ctrl.m_bubble = 1'b1;
         end
      endcase
   end

   assign pipe.F_stall  = ctrl.f_stall;
   assign pipe.D_stall  = ctrl.d_stall;
   assign pipe.D_bubble = ctrl.d_bubble;
   assign pipe.E_bubble = ctrl.e_bubble;
   assign pipe.M_bubble = ctrl.m_bubble;
   assign pipe.W_stall  = ctrl.w_stall;
   assign pipe.set_cc   = ctrl.set_cc;
   assign run_state     = state;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RS_INIT;
         prog_stat <= S_AOK;
         cycle_cnt <= '0;
         instr_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         unique case (state)
            RS_INIT: begin
               state     <= RS_RUN;
               cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            RS_RUN: begin
               cycle_cnt <= cycle_cnt + CNT_W'(1);
               if ((pipe.W_stat == S_AOK) && (pipe.W_icode != I_NOP))
                  instr_cnt <= instr_cnt + CNT_W'(1);
               if (run_ctrl.f_stall)
                  stall_cnt <= stall_cnt + CNT_W'(1);
               if (is_exc(pipe.W_stat)) begin
                  state     <= RS_HALT;
                  prog_stat <= pipe.W_stat;
               end
            end
            RS_HALT: state <= RS_HALT;
            default: state <= RS_INIT;
         endcase
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and run-state controller for the five-stage Y86-64 pipeline. It drives the stall/bubble inputs of the F, D, E, M and W pipeline registers and the condition-code write enable. It runs a small run-state machine (INIT / RUN / HALT) that flushes the pipe after reset and freezes it once a non-AOK status retires. It also keeps sticky program status and performance counters for the bench and top level.

## Interface
- CNT_W, 32, width of cycle/instruction/stall counters
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- D_icode  in  4  icode in D register
- d_srcA, d_srcB  in  4  decode source registers (0xF = none)
- E_icode  in  4  icode in E register
- E_dstM  in  4  memory destination register in E (0xF = none)
- e_Cnd  in  1  branch condition computed in execute
- M_icode  in  4  icode in M register
- m_stat  in  3  status produced by memory stage
- W_icode  in  4  icode in W register
- W_stat  in  3  status in W register
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1  pipeline register controls
- set_cc  out  1  condition-code write enable for execute
- run_state  out  2  INIT=0, RUN=1, HALT=2
- prog_stat  out  3  sticky program status
- cycle_cnt, instr_cnt, stall_cnt  out  CNT_W  performance counters

## Operation
- Encodings: icodes HALT=0, NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=B. Status codes AOK=1, HLT=2, ADR=3, INS=4. "Exception" means stat ∈ {HLT, ADR, INS}.
- load_use = E_icode ∈ {MRMOVQ, POPQ} ∧ E_dstM≠0xF ∧ (E_dstM==d_srcA ∨ E_dstM==d_srcB).
- ret_pend = RET ∈ {D_icode, E_icode, M_icode}.
- mispred = E_icode==JXX ∧ !e_Cnd.
- In RUN, all outputs are combinational:
  - F_stall = load_use ∨ ret_pend
  - D_stall = load_use
  - D_bubble = mispred ∨ (!load_use ∧ ret_pend)
  - E_bubble = mispred ∨ load_use
  - M_bubble = exc(m_stat) ∨ exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==OPQ ∧ !exc(m_stat) ∧ !exc(W_stat)
- INIT: D_bubble=E_bubble=M_bubble=1, all stalls 0, set_cc=0.
- HALT: F_stall=D_stall=W_stall=1, all bubbles 0, set_cc=0. The pipe is frozen.
- FSM transitions:
  - reset → INIT
  - INIT → RUN after exactly one cycle
  - RUN → HALT on the edge where exc(W_stat)
  - HALT is terminal; only rst_n exits it
- prog_stat: resets to AOK. Loads W_stat on the RUN→HALT edge, then holds.
- cycle_cnt increments every cycle in INIT and RUN. It freezes in HALT.
- instr_cnt increments in RUN when W_stat==AOK ∧ W_icode≠NOP. NOPs, including bubbles, are not counted.
- stall_cnt increments in RUN when F_stall==1.
- All counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Async reset values: run_state=INIT, prog_stat=AOK, all counters 0. Control outputs follow INIT values while reset is low.
- Control outputs have zero-cycle latency from stage inputs; they are sampled by the pipeline registers on the same edge.
- Counters and FSM are registered; each update is visible the cycle after its qualifying condition.
- Simultaneous load_use ∧ ret_pend: D_stall=1, D_bubble=0 (stall wins), F_stall=1.
- Simultaneous mispred ∧ ret_pend: D_bubble=1, F_stall=1.
- exc(W_stat) on the RUN cycle itself: W_stall=1 and M_bubble=1 on that cycle; HALT applies from the next cycle.
- Reset asserted mid-run or in HALT: immediate return to INIT; prog_stat cleared.

## Structure
- Shared package y86_pkg holds the icode constants, stat constants, RNONE=0xF and the run_state encoding. It is shared with the pipeline register and stage modules.
- One sub-module, hazard_detect: purely combinational, computes load_use, ret_pend, mispred and the RUN-mode control vector. pipe_ctrl wraps it with the FSM, the HALT/INIT overrides and the counters.

## Test plan
- Reset release: rst_n low→high, all inputs quiet (icodes NOP, stats AOK).
  - Response: one INIT cycle with D/E/M_bubble=1, then run_state=1; cycle_cnt=5 after 5 cycles.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3.
  - Response: F_stall=D_stall=E_bubble=1, D_bubble=0.
  - Same with E_dstM=0xF: all controls 0.
- Mispredict plus ret: E_icode=7, e_Cnd=0, D_icode=9.
  - Response: D_bubble=E_bubble=1, F_stall=1, D_stall=0.
- Exception retire: m_stat=3 (ADR).
  - Response: M_bubble=1 and set_cc=0 with E_icode=6.
  - Next cycle, W_stat=3: W_stall=1; following cycle run_state=2, prog_stat=3; cycle_cnt frozen thereafter.
- Counters: 10 RUN cycles retiring 4 AOK OPQ and 6 NOP.
  - Response: instr_cnt=4.
  - Force F_stall for 3 of those cycles: stall_cnt=3.
  - With CNT_W=4, 17 RUN cycles from 0: cycle_cnt wraps to 1.
- Reset from HALT: rst_n pulse while run_state=2.
  - Response: run_state=0, prog_stat=1, counters 0 asynchronously.
